// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array job sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        DONE
    } seq_state_t;

    // Width helpers used to derive ROW_IDX_W / STG_CNT_W from instance parameters.
    function automatic int unsigned row_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned stg_cnt_w(input int unsigned s);
        return (s > 0) ? $clog2(s + 1) : 1;
    endfunction

endpackage

// File: rtl/systolic_sequencer_stage_timer.sv
// Counts STAGE_CYCLES enabled cycles and pulses stage_tick on the last cycle of each stage.
module stage_timer
    import systolic_pkg::*;
#(
    parameter int unsigned STAGE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic stage_tick
);

    localparam int unsigned STG_CNT_W = stg_cnt_w(STAGE_CYCLES);

    logic [STG_CNT_W-1:0] count;

    assign stage_tick = enable && (count == STG_CNT_W'(STAGE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= stage_tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Job-level controller for an N x N weight-stationary systolic array:
// weight load, skewed per-row multiply enables, drain window, done pulse.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE  = 4,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned STAGE_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           general_enable,
    input  logic                           abort,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [CNT_W-1:0]               num_vectors,
    output logic [MATRIX_SIZE-1:0]         load_weight,
    output logic [$clog2(MATRIX_SIZE)-1:0] weight_row_idx,
    output logic [MATRIX_SIZE-1:0]         enable_mult,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned ROW_IDX_W = row_idx_w(MATRIX_SIZE);

    if (MATRIX_SIZE < 2 || STAGE_CYCLES < 1 || DATA_SIZE < 1) begin : g_param_check
        $error("systolic_sequencer: MATRIX_SIZE must be >= 2, STAGE_CYCLES >= 1, DATA_SIZE >= 1");
    end

    seq_state_t             state, state_n;
    logic [ROW_IDX_W-1:0]   row, row_n;
    logic [CNT_W:0]         stage, stage_n;
    logic [CNT_W-1:0]       vnum, vnum_n;
    logic [MATRIX_SIZE-1:0] load_n, en_n;
    logic [ROW_IDX_W-1:0]   idx_n;
    logic                   busy_n, done_n;
    logic [CNT_W+1:0]       last_stage;
    logic                   timer_clear, timer_en, stage_tick;

    // Row r multiplies during stages r .. r+V-1 (diagonal skew across rows).
    function automatic logic [MATRIX_SIZE-1:0] row_enables(input logic [CNT_W:0] s,
                                                           input logic [CNT_W-1:0] v);
        logic [MATRIX_SIZE-1:0] m;
        logic [CNT_W+1:0]       se;
        logic [CNT_W+1:0]       re;
        m  = '0;
        se = {1'b0, s};
        for (int unsigned r = 0; r < MATRIX_SIZE; r++) begin
            re   = (CNT_W + 2)'(r);
            m[r] = (se >= re) && (se < re + {2'b00, v});
        end
        return m;
    endfunction

    assign start_ready = (state == IDLE) && general_enable;
    assign last_stage  = {2'b00, vnum} + (CNT_W + 2)'(MATRIX_SIZE - 2);

    assign timer_en    = general_enable && !abort && (state == COMPUTE || state == DRAIN);
    assign timer_clear = general_enable && (abort || !(state == COMPUTE || state == DRAIN));

    stage_timer #(
        .STAGE_CYCLES(STAGE_CYCLES)
    ) u_stage_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (timer_clear),
        .enable    (timer_en),
        .stage_tick(stage_tick)
    );

    // Next-state and next-output values; every output is registered below.
    always_comb begin
        state_n = state;
        row_n   = row;
        stage_n = stage;
        vnum_n  = vnum;
        load_n  = '0;
        idx_n   = '0;
        en_n    = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start_valid && start_ready) begin
                    state_n = LOAD;
                    vnum_n  = (num_vectors == '0) ? CNT_W'(1) : num_vectors;
                    row_n   = '0;
                    stage_n = '0;
                    load_n  = MATRIX_SIZE'(1);
                    busy_n  = 1'b1;
                end
            end
            LOAD: begin
                busy_n = 1'b1;
                if (row == ROW_IDX_W'(MATRIX_SIZE - 1)) begin
                    state_n = COMPUTE;
                    row_n   = '0;
                    stage_n = '0;
                    en_n    = row_enables('0, vnum);
                end else begin
                    row_n  = row + 1'b1;
                    load_n = MATRIX_SIZE'(1) << row_n;
                    idx_n  = row_n;
                end
            end
            COMPUTE: begin
                busy_n = 1'b1;
                en_n   = row_enables(stage, vnum);
                if (stage_tick) begin
                    if ({1'b0, stage} == last_stage) begin
                        state_n = DRAIN;
                        stage_n = '0;
                        en_n    = '0;
                    end else begin
                        stage_n = stage + 1'b1;
                        en_n    = row_enables(stage_n, vnum);
                    end
                end
            end
            DRAIN: begin
                busy_n = 1'b1;
                if (stage_tick) begin
                    if (stage == (CNT_W + 1)'(MATRIX_SIZE - 1)) begin
                        state_n = DONE;
                        stage_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        stage_n = stage + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                vnum_n  = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort && state != IDLE) begin
            state_n = IDLE;
            row_n   = '0;
            stage_n = '0;
            vnum_n  = '0;
            load_n  = '0;
            idx_n   = '0;
            en_n    = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            row            <= '0;
            stage          <= '0;
            vnum           <= '0;
            load_weight    <= '0;
            weight_row_idx <= '0;
            enable_mult    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (general_enable) begin
            state          <= state_n;
            row            <= row_n;
            stage          <= stage_n;
            vnum           <= vnum_n;
            load_weight    <= load_n;
            weight_row_idx <= idx_n;
            enable_mult    <= en_n;
            busy           <= busy_n;
            done           <= done_n;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench: per-cycle expected outputs are queued when a job is started and popped each cycle.
module tb_systolic_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          general_enable;
    logic          abort;
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] num_vectors;
    logic [N-1:0]  load_weight;
    logic [IW-1:0] weight_row_idx;
    logic [N-1:0]  enable_mult;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  load;
        logic [IW-1:0] idx;
        logic [N-1:0]  en;
        logic          busy;
        logic          done;
        logic          rdy;
    } exp_t;

    exp_t exp_q[$];

    systolic_sequencer #(
        .MATRIX_SIZE (N),
        .DATA_SIZE   (32),
        .STAGE_CYCLES(S),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .general_enable(general_enable),
        .abort         (abort),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .num_vectors   (num_vectors),
        .load_weight   (load_weight),
        .weight_row_idx(weight_row_idx),
        .enable_mult   (enable_mult),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_rec(input exp_t e, input string tag);
        chk({tag, ".load_weight"},    32'(load_weight),    32'(e.load));
        chk({tag, ".weight_row_idx"}, 32'(weight_row_idx), 32'(e.idx));
        chk({tag, ".enable_mult"},    32'(enable_mult),    32'(e.en));
        chk({tag, ".busy"},           32'(busy),           32'(e.busy));
        chk({tag, ".done"},           32'(done),           32'(e.done));
        chk({tag, ".start_ready"},    32'(start_ready),    32'(e.rdy));
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e.load = '0; e.idx = '0; e.en = '0; e.busy = 1'b0; e.done = 1'b0; e.rdy = 1'b1;
        return e;
    endfunction

    // Reference job profile built directly from the phase lengths and the diagonal rule.
    function automatic void push_job(input int v);
        exp_t e;
        logic [N-1:0] one;
        one = 1;
        for (int i = 0; i < int'(N); i++) begin
            e = idle_rec(); e.rdy = 1'b0; e.busy = 1'b1;
            e.load = one << i; e.idx = IW'(i);
            exp_q.push_back(e);
        end
        for (int s = 0; s <= v + int'(N) - 2; s++) begin
            for (int c = 0; c < int'(S); c++) begin
                e = idle_rec(); e.rdy = 1'b0; e.busy = 1'b1;
                for (int r = 0; r < int'(N); r++) e.en[r] = (s >= r) && (s < r + v);
                exp_q.push_back(e);
            end
        end
        for (int c = 0; c < int'(N * S); c++) begin
            e = idle_rec(); e.rdy = 1'b0; e.busy = 1'b1;
            exp_q.push_back(e);
        end
        e = idle_rec(); e.rdy = 1'b0; e.busy = 1'b1; e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at an IDLE cycle; drives start there and checks every following cycle.
    task automatic run_job(input logic [CW-1:0] nv, input int stall_at, input int abort_at,
                           input int reset_at, input bit keep_start, input bit abort_on_start);
        exp_t e;
        int idx;
        chk("ready_idle", 32'(start_ready), 32'd1);
        push_job((nv == 0) ? 1 : int'(nv));
        num_vectors = nv;
        start_valid = 1'b1;
        abort       = abort_on_start;
        step();
        start_valid = keep_start;
        abort       = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_rec(e, "job");
            if (idx == stall_at) begin
                general_enable = 1'b0;
                repeat (10) begin
                    step();
                    e.rdy = 1'b0;
                    check_rec(e, "stall");
                end
                general_enable = 1'b1;
            end
            if (idx == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                exp_q.delete();
                check_rec(idle_rec(), "abort");
                repeat (45) begin
                    step();
                    chk("abort.no_done", 32'(done), 32'd0);
                end
                return;
            end
            if (idx == reset_at) begin
                #2 reset_n = 1'b0;
                #1;
                check_rec(idle_rec(), "async_reset");
                #2 reset_n = 1'b1;
                step();
                exp_q.delete();
                check_rec(idle_rec(), "after_reset");
                return;
            end
            idx++;
            step();
        end
        check_rec(idle_rec(), "post_done");
    endtask

    initial begin
        reset_n        = 1'b0;
        general_enable = 1'b1;
        abort          = 1'b0;
        start_valid    = 1'b0;
        num_vectors    = '0;
        #3;
        check_rec(idle_rec(), "reset");
        general_enable = 1'b0;
        #1;
        chk("reset.ready_gated", 32'(start_ready), 32'd0);
        general_enable = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        check_rec(idle_rec(), "idle");

        // Plain V=2 job.
        run_job(16'd2, -1, -1, -1, 1'b0, 1'b0);
        // num_vectors=0 behaves as V=1; abort raised with start in IDLE is ignored.
        run_job(16'd0, -1, -1, -1, 1'b0, 1'b1);
        // Ten-cycle stall while LOAD row 2 is presented.
        run_job(16'd2, 2, -1, -1, 1'b0, 1'b0);
        // Abort on COMPUTE cycle 7.
        run_job(16'd3, -1, int'(N) + 7, -1, 1'b0, 1'b0);
        // start_valid held high across two back-to-back jobs.
        run_job(16'd1, -1, -1, -1, 1'b1, 1'b0);
        run_job(16'd1, -1, -1, -1, 1'b0, 1'b0);
        // Asynchronous reset in the middle of DRAIN.
        run_job(16'd2, -1, -1, int'(N) + 5 * int'(S) + 5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
